// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared constants and types for the PS/2 keyboard receiver.
//   Scan codes for the prefixes and the five game keys, the event record
//   pushed into the event FIFO, and the state enums for the frame and decode FSMs.
package ps2_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_ROTATE = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_DROP   = 8'h29;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_DATA,
    FR_PARITY,
    FR_STOP
  } frame_state_t;

  typedef enum logic [1:0] {
    DEC_NORM,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK
  } dec_state_t;

  // Odd parity holds when the byte plus its parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// ps2_key_ctrl_if -- key event stream from the PS/2 controller to the game logic.
//   evt_valid  head event present
//   evt_ready  consumer takes the head when evt_valid && evt_ready
//   evt_code   scan code with prefixes stripped
//   evt_ext    event was E0-prefixed
//   evt_break  event was a release
// master = controller side, slave = consumer side.
interface ps2_key_ctrl_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;

  modport master (output evt_valid, evt_code, evt_ext, evt_break, input evt_ready);
  modport slave  (input evt_valid, evt_code, evt_ext, evt_break, output evt_ready);
endinterface

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame -- PS/2 device-to-host frame receiver.
//   Synchronizes both pins, deglitches ps2_clk, shifts in 11-bit frames on the
//   filtered falling edges and reports each good byte or the reason it was dropped.
// Ports
//   clk, reset     system clock, synchronous active-high reset
//   ps2_clk/data   raw PS/2 pins (asynchronous)
//   byte_strobe    1-cycle pulse, rx_byte holds a good byte
//   rx_byte        last good byte
//   err_parity     1-cycle pulse, frame dropped on odd-parity failure
//   err_frame      1-cycle pulse, frame dropped on bad stop bit or inter-edge timeout
//
// state     | meaning
// FR_IDLE   | waiting for a start bit (fall with data low)
// FR_DATA   | shifting in 8 data bits, LSB first
// FR_PARITY | next fall carries the parity bit
// FR_STOP   | next fall carries the stop bit; byte is judged here
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 4000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_strobe,
  output logic [7:0] rx_byte,
  output logic       err_parity,
  output logic       err_frame
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync, data_sync;
  logic          clk_s, data_s;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          filt_done, fall;

  frame_state_t  state, state_n;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_cnt;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          timeout;
  logic          strobe_n, perr_n, ferr_n;

  // Synchronizers reset to the idle (pulled-up) level so reset never fakes a fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // filt_done marks the FILTER_LEN-th consecutive sample differing from the filtered level.
  assign filt_done = (clk_s != clk_filt) && (filt_cnt == FW'(FILTER_LEN - 1));
  assign fall      = filt_done && clk_filt;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_done) begin
      clk_filt <= clk_s;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  // Abort when TIMEOUT_CYCLES pass inside a frame without a fall.
  assign timeout = (state != FR_IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= FR_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    strobe_n = 1'b0;
    perr_n   = 1'b0;
    ferr_n   = 1'b0;
    if (timeout) begin
      state_n = FR_IDLE;
      ferr_n  = 1'b1;
    end else if (fall) begin
      case (state)
        FR_IDLE:   if (!data_s) state_n = FR_DATA;
        FR_DATA:   if (bit_cnt == 3'd7) state_n = FR_PARITY;
        FR_PARITY: state_n = FR_STOP;
        FR_STOP: begin
          state_n = FR_IDLE;
          // A bad stop bit masks a parity fault.
          if (!data_s)                             ferr_n   = 1'b1;
          else if (!odd_parity_ok(shift_reg, par_bit)) perr_n = 1'b1;
          else                                     strobe_n = 1'b1;
        end
        default:   state_n = FR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_strobe <= 1'b0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      rx_byte     <= '0;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      par_bit     <= 1'b0;
      to_cnt      <= '0;
    end else begin
      byte_strobe <= strobe_n;
      err_parity  <= perr_n;
      err_frame   <= ferr_n;
      if (strobe_n) rx_byte <= shift_reg;
      if (fall && state == FR_IDLE) bit_cnt <= '0;
      if (fall && state == FR_DATA) begin
        shift_reg <= {data_s, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 3'd1;
      end
      if (fall && state == FR_PARITY) par_bit <= data_s;
      if (state == FR_IDLE || fall) to_cnt <= '0;
      else                          to_cnt <= to_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl -- host-side PS/2 keyboard controller (receive only).
//   Turns the received byte stream into make/break events, queues them in a
//   small FIFO and tracks held levels of the five game keys.
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   ps2_clk/ps2_data  PS/2 pins (inputs only, never driven)
//   evt               event stream, master side of ps2_key_ctrl_if
//   key_*             held levels for left/right/rotate/down/drop
//   err_parity        pulse: frame dropped on parity
//   err_frame         pulse: frame dropped on stop bit or timeout
//   err_overflow      pulse: event dropped, FIFO full
//
// state       | meaning
// DEC_NORM    | no prefix pending
// DEC_EXT     | E0 seen
// DEC_BRK     | F0 seen
// DEC_EXT_BRK | E0 and F0 seen (either order)
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 4000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  ps2_key_ctrl_if.master evt,
  output logic          key_left,
  output logic          key_right,
  output logic          key_rotate,
  output logic          key_down,
  output logic          key_drop,
  output logic          err_parity,
  output logic          err_frame,
  output logic          err_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic       byte_strobe;
  logic [7:0] rx_byte;

  ps2_rx_frame #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_strobe(byte_strobe),
    .rx_byte    (rx_byte),
    .err_parity (err_parity),
    .err_frame  (err_frame)
  );

  dec_state_t dec, dec_n;
  logic       emit;
  ps2_evt_t   emit_evt;

  always_ff @(posedge clk) begin
    if (reset) dec <= DEC_NORM;
    else       dec <= dec_n;
  end

  always_comb begin
    dec_n         = dec;
    emit          = 1'b0;
    emit_evt.code = rx_byte;
    emit_evt.ext  = (dec == DEC_EXT) || (dec == DEC_EXT_BRK);
    emit_evt.brk  = (dec == DEC_BRK) || (dec == DEC_EXT_BRK);
    if (byte_strobe) begin
      if (rx_byte == SC_E0) begin
        if (dec == DEC_NORM)     dec_n = DEC_EXT;
        else if (dec == DEC_BRK) dec_n = DEC_EXT_BRK;
      end else if (rx_byte == SC_F0) begin
        if (dec == DEC_NORM)     dec_n = DEC_BRK;
        else if (dec == DEC_EXT) dec_n = DEC_EXT_BRK;
      end else begin
        emit  = 1'b1;
        dec_n = DEC_NORM;
      end
    end
  end

  // Levels follow every emitted event, including ones the FIFO drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_left   <= 1'b0;
      key_right  <= 1'b0;
      key_rotate <= 1'b0;
      key_down   <= 1'b0;
      key_drop   <= 1'b0;
    end else if (emit) begin
      case (emit_evt.code)
        SC_LEFT:   key_left   <= !emit_evt.brk;
        SC_RIGHT:  key_right  <= !emit_evt.brk;
        SC_ROTATE: key_rotate <= !emit_evt.brk;
        SC_DOWN:   key_down   <= !emit_evt.brk;
        SC_DROP:   key_drop   <= !emit_evt.brk;
        default:   ;
      endcase
    end
  end

  ps2_evt_t        mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            empty, full, pop, push;
  ps2_evt_t        head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = evt.evt_valid && evt.evt_ready;
  // A pop in the same cycle frees the slot the push writes into.
  assign push  = emit && (!full || pop);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= emit_evt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      err_overflow <= emit && full && !pop;
    end
  end

  // Gating with valid keeps the outputs at zero after reset without clearing the array.
  assign evt.evt_valid = !empty;
  assign evt.evt_code  = evt.evt_valid ? head.code : 8'h00;
  assign evt.evt_ext   = evt.evt_valid && head.ext;
  assign evt.evt_break = evt.evt_valid && head.brk;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
module tb_ps2_key_ctrl;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 4000;
  localparam int FIFO_DEPTH     = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic key_left, key_right, key_rotate, key_down, key_drop;
  logic err_parity, err_frame, err_overflow;

  ps2_key_ctrl_if evt_if ();

  ps2_key_ctrl #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .FIFO_DEPTH    (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .evt         (evt_if),
    .key_left    (key_left),
    .key_right   (key_right),
    .key_rotate  (key_rotate),
    .key_down    (key_down),
    .key_drop    (key_drop),
    .err_parity  (err_parity),
    .err_frame   (err_frame),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } exp_evt_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stop_fall_cyc = 0;
  bit lat_chk = 1'b1;

  // behavioural model state
  exp_evt_t exp_q[$];
  bit m_ext, m_brk;
  bit m_left, m_right, m_rotate, m_down, m_drop;
  int e_perr = 0, e_ferr = 0, e_ovf = 0;

  // observed
  int n_perr = 0, n_ferr = 0, n_ovf = 0;
  logic [7:0] last_code;
  logic last_ext, last_brk;
  logic [7:0] drained[$];

  bit hold_prev = 1'b0;
  logic [7:0] prev_code;
  logic prev_ext, prev_brk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ext = 0; m_brk = 0;
    m_left = 0; m_right = 0; m_rotate = 0; m_down = 0; m_drop = 0;
  endtask

  // Byte-level meaning of the key stream: prefixes accumulate, any other byte is a key event.
  task automatic model_byte(input logic [7:0] b);
    exp_evt_t e;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      e.code = b; e.ext = m_ext; e.brk = m_brk;
      if (exp_q.size() >= FIFO_DEPTH) e_ovf++;
      else exp_q.push_back(e);
      case (b)
        8'h6B: m_left   = !m_brk;
        8'h74: m_right  = !m_brk;
        8'h75: m_rotate = !m_brk;
        8'h72: m_down   = !m_brk;
        8'h29: m_drop   = !m_brk;
        default: ;
      endcase
      m_ext = 0; m_brk = 0;
    end
  endtask

  // Device-side frame: data changes while clock is high, sampled on the fall.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] bits;
    bits[0]   = 1'b0;
    bits[8:1] = b;
    bits[9]   = (~^b) ^ bad_par;
    bits[10]  = !bad_stop;
    for (int i = 0; i < 11; i++) begin
      ps2_data = bits[i];
      wait_cyc(10);
      ps2_clk = 1'b0;
      if (i == 10) stop_fall_cyc = cyc;
      wait_cyc(20);
      ps2_clk = 1'b1;
      wait_cyc(10);
    end
    ps2_data = 1'b1;
    wait_cyc(40);
  endtask

  task automatic send_partial(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = (i == 0) ? 1'b0 : 1'b1;
      wait_cyc(10);
      ps2_clk = 1'b0;
      wait_cyc(20);
      ps2_clk = 1'b1;
      wait_cyc(10);
    end
    ps2_data = 1'b1;
  endtask

  task automatic key_byte(input logic [7:0] b);
    model_byte(b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_key_left"},   key_left,   m_left);
    chk({tag, "_key_right"},  key_right,  m_right);
    chk({tag, "_key_rotate"}, key_rotate, m_rotate);
    chk({tag, "_key_down"},   key_down,   m_down);
    chk({tag, "_key_drop"},   key_drop,   m_drop);
    chk({tag, "_n_perr"},     n_perr,     e_perr);
    chk({tag, "_n_ferr"},     n_ferr,     e_ferr);
    chk({tag, "_n_ovf"},      n_ovf,      e_ovf);
    if (evt_if.evt_ready) chk({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {evt_if.evt_valid, evt_if.evt_code, evt_if.evt_ext, evt_if.evt_break,
              key_left, key_right, key_rotate, key_down, key_drop,
              err_parity, err_frame, err_overflow}, 0);
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    exp_evt_t e;
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (err_parity)   n_perr++;
      if (err_frame)    n_ferr++;
      if (err_overflow) n_ovf++;
      if (hold_prev) begin
        checks++;
        if (!(evt_if.evt_valid && evt_if.evt_code == prev_code &&
              evt_if.evt_ext == prev_ext && evt_if.evt_break == prev_brk)) begin
          failures++;
          $display("FAIL evt_hold actual=%b/%h/%b/%b required=1/%h/%b/%b", evt_if.evt_valid,
                   evt_if.evt_code, evt_if.evt_ext, evt_if.evt_break, prev_code, prev_ext, prev_brk);
        end
      end
      if (evt_if.evt_valid && evt_if.evt_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL evt_unexpected actual=%h/%b/%b required=none", evt_if.evt_code,
                   evt_if.evt_ext, evt_if.evt_break);
        end else begin
          e = exp_q.pop_front();
          if (evt_if.evt_code !== e.code || evt_if.evt_ext !== e.ext || evt_if.evt_break !== e.brk) begin
            failures++;
            $display("FAIL evt_fields actual=%h/%b/%b required=%h/%b/%b", evt_if.evt_code,
                     evt_if.evt_ext, evt_if.evt_break, e.code, e.ext, e.brk);
          end
        end
        if (lat_chk) begin
          checks++;
          if (cyc - stop_fall_cyc > FILTER_LEN + 5) begin
            failures++;
            $display("FAIL evt_latency actual=%0d required<=%0d", cyc - stop_fall_cyc, FILTER_LEN + 5);
          end
        end
        last_code = evt_if.evt_code;
        last_ext  = evt_if.evt_ext;
        last_brk  = evt_if.evt_break;
        drained.push_back(evt_if.evt_code);
      end
      hold_prev = evt_if.evt_valid && !evt_if.evt_ready;
      prev_code = evt_if.evt_code;
      prev_ext  = evt_if.evt_ext;
      prev_brk  = evt_if.evt_break;
    end
  end

  initial begin
    evt_if.evt_ready = 1'b1;
    model_reset();
    wait_cyc(5);
    chk_zero("in_reset");
    reset = 1'b0;
    wait_cyc(20);
    chk_zero("after_reset");

    // make left
    key_byte(8'h6B);
    chk("make_code", last_code, 8'h6B);
    chk("make_ext", last_ext, 1'b0);
    chk("make_brk", last_brk, 1'b0);
    chk("make_key_left", key_left, 1'b1);
    chk_state("make");

    // break left
    key_byte(8'hF0);
    key_byte(8'h6B);
    chk("break_brk", last_brk, 1'b1);
    chk("break_key_left", key_left, 1'b0);
    chk_state("break");

    // extended rotate make then break
    key_byte(8'hE0);
    key_byte(8'h75);
    chk("ext_make_rotate", key_rotate, 1'b1);
    key_byte(8'hE0);
    key_byte(8'hF0);
    key_byte(8'h75);
    chk("ext_brk_evt", {last_code, last_ext, last_brk}, {8'h75, 1'b1, 1'b1});
    chk("ext_brk_rotate", key_rotate, 1'b0);
    chk_state("ext");

    // repeated prefixes, F0 before E0
    key_byte(8'h74);
    key_byte(8'hF0);
    key_byte(8'hF0);
    key_byte(8'hE0);
    key_byte(8'hE0);
    key_byte(8'h74);
    chk("rep_pfx_evt", {last_code, last_ext, last_brk}, {8'h74, 1'b1, 1'b1});
    chk_state("rep_pfx");

    // parity error, then good drop key
    e_perr++;
    send_frame(8'h29, 1'b1, 1'b0);
    chk_state("par_err");
    key_byte(8'h29);
    chk("par_next_drop", key_drop, 1'b1);
    chk_state("par_next");

    // bad stop bit, and both faults together
    e_ferr++;
    send_frame(8'h72, 1'b0, 1'b1);
    chk_state("stop_err");
    e_ferr++;
    send_frame(8'h72, 1'b1, 1'b1);
    chk_state("both_err");

    // timeout mid-frame
    e_ferr++;
    send_partial(4);
    wait_cyc(TIMEOUT_CYCLES + 200);
    chk_state("timeout");
    key_byte(8'h72);
    chk("timeout_next_down", key_down, 1'b1);
    chk_state("timeout_next");

    // overflow: consumer stalled, five makes
    evt_if.evt_ready = 1'b0;
    lat_chk = 1'b0;
    key_byte(8'h16);
    key_byte(8'h1E);
    key_byte(8'h26);
    key_byte(8'h25);
    key_byte(8'h2E);
    chk("ovf_valid", evt_if.evt_valid, 1'b1);
    chk("ovf_head", evt_if.evt_code, 8'h16);
    chk("ovf_pulses", n_ovf, 1);
    chk_state("ovf");
    drained.delete();
    evt_if.evt_ready = 1'b1;
    wait_cyc(20);
    chk("drain_count", drained.size(), 4);
    if (drained.size() == 4) begin
      chk("drain_0", drained[0], 8'h16);
      chk("drain_1", drained[1], 8'h1E);
      chk("drain_2", drained[2], 8'h26);
      chk("drain_3", drained[3], 8'h25);
    end
    chk_state("drain");
    lat_chk = 1'b1;

    // reset mid-frame
    send_partial(5);
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(3);
    chk_zero("mid_reset");
    wait_cyc(15);
    reset = 1'b0;
    model_reset();
    wait_cyc(1);
    chk_zero("post_mid_reset");
    wait_cyc(60);
    chk_state("post_reset_idle");
    key_byte(8'h6B);
    chk("post_reset_evt", {last_code, last_ext, last_brk}, {8'h6B, 1'b0, 1'b0});
    chk_state("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
